// File: rtl/dvi_video_sequencer_if.sv
// Video timing bundle from the sequencer to the TMDS encoders and pattern generator.
interface dvi_video_sequencer_if;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic [2:0] pattern;

  modport master (
    output de,
    output hsync,
    output vsync,
    output x,
    output y,
    output frame_start,
    output pattern
  );

  modport slave (
    input de,
    input hsync,
    input vsync,
    input x,
    input y,
    input frame_start,
    input pattern
  );
endinterface

// File: rtl/dvi_video_sequencer.sv
// Raster timing generator and frame-synchronous test-pattern selector for the DVI path.
// All video outputs are registered one cycle behind the internal hcnt/vcnt counters.
module dvi_video_sequencer #(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned H_FP           = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BP           = 48,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_FP           = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BP           = 33,
  parameter int unsigned SYNC_POL       = 0,
  parameter int unsigned NUM_PATTERNS   = 8,
  parameter int unsigned AUTO_FRAMES    = 120,
  parameter int unsigned LOCKOUT_FRAMES = 4
) (
  input  logic                         pixclk_i,
  input  logic                         reset_i,
  input  logic                         btn_next_i,
  input  logic                         auto_en_i,
  dvi_video_sequencer_if.master        video_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned AutoW   = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam int unsigned LockW   = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;

  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAct    = 10'(H_ACTIVE);
  localparam logic [9:0] VAct    = 10'(V_ACTIVE);
  localparam logic [9:0] HsBegin = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsBegin = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic             SyncOn   = (SYNC_POL != 0);
  localparam logic [2:0]       PatLast  = 3'(NUM_PATTERNS - 1);
  localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_FRAMES - 1);
  localparam logic [LockW-1:0] LockLoad = LockW'(LOCKOUT_FRAMES);

  // Raster counters and registered timing outputs
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic       fs_q, fs_d;
  logic       frame_bound;

  // Pattern selection state
  logic [2:0]       pattern_q, pattern_d;
  logic             btn_meta_q, btn_sync_q, btn_prev_q;
  logic             pend_q, pend_d;
  logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;
  logic [LockW-1:0] lock_q, lock_d;
  logic             btn_rise;
  logic             btn_accept;
  logic             auto_due;

  assign frame_bound = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = 10'd0;
      vcnt_d = (vcnt_q == VLast) ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  always_comb begin
    de_d    = (hcnt_q < HAct) && (vcnt_q < VAct);
    hsync_d = ((hcnt_q >= HsBegin) && (hcnt_q < HsEnd)) ? SyncOn : ~SyncOn;
    vsync_d = ((vcnt_q >= VsBegin) && (vcnt_q < VsEnd)) ? SyncOn : ~SyncOn;
    fs_d    = frame_bound;
  end

  always_ff @(posedge pixclk_i) begin
    if (reset_i) begin
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      de_q    <= 1'b0;
      hsync_q <= ~SyncOn;
      vsync_q <= ~SyncOn;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      fs_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      x_q     <= hcnt_q;
      y_q     <= vcnt_q;
      fs_q    <= fs_d;
    end
  end

  // Button edges only count when no lockout is running
  assign btn_rise   = btn_sync_q & ~btn_prev_q;
  assign btn_accept = btn_rise && (lock_q == '0);
  assign auto_due   = auto_en_i && (auto_cnt_q == AutoLast);

  always_comb begin
    pattern_d  = pattern_q;
    pend_d     = pend_q | btn_accept;
    auto_cnt_d = auto_en_i ? auto_cnt_q : '0;
    lock_d     = lock_q;
    if (frame_bound) begin
      if (pend_q || auto_due) begin
        pattern_d  = (pattern_q == PatLast) ? 3'd0 : pattern_q + 3'd1;
        auto_cnt_d = '0;
        if (pend_q) begin
          // Lockout restarts here, so an edge landing on this very cycle is dropped
          lock_d = LockLoad;
          pend_d = 1'b0;
        end else begin
          pend_d = btn_accept;
        end
      end else begin
        auto_cnt_d = auto_en_i ? auto_cnt_q + AutoW'(1) : '0;
        if (lock_q != '0) begin
          lock_d = lock_q - LockW'(1);
        end
        pend_d = btn_accept;
      end
    end
  end

  always_ff @(posedge pixclk_i) begin
    if (reset_i) begin
      pattern_q  <= 3'd0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      auto_cnt_q <= '0;
      lock_q     <= '0;
    end else begin
      pattern_q  <= pattern_d;
      btn_meta_q <= btn_next_i;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      pend_q     <= pend_d;
      auto_cnt_q <= auto_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign video_o.de          = de_q;
  assign video_o.hsync       = hsync_q;
  assign video_o.vsync       = vsync_q;
  assign video_o.x           = x_q;
  assign video_o.y           = y_q;
  assign video_o.frame_start = fs_q;
  assign video_o.pattern     = pattern_q;

endmodule

// File: tb/tb_dvi_video_sequencer.sv
// Scoreboard bench: a reference process queues expected raster outputs per cycle, the stimulus
// queues the expected pattern for each frame start, and a monitor pops and compares both.
module tb_dvi_video_sequencer;

  // Small raster: 32 x 12 totals, frame = 384 cycles
  localparam int FRAME = 384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic auto_en = 1'b0;

  always #5 clk = ~clk;

  dvi_video_sequencer_if v0 ();
  dvi_video_sequencer_if v1 ();
  dvi_video_sequencer_if v2 ();

  dvi_video_sequencer #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(0), .NUM_PATTERNS(8), .AUTO_FRAMES(3), .LOCKOUT_FRAMES(4)
  ) u_dut_pol0 (
    .pixclk_i  (clk),
    .reset_i   (rst),
    .btn_next_i(btn),
    .auto_en_i (auto_en),
    .video_o   (v0)
  );

  dvi_video_sequencer #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1), .NUM_PATTERNS(8), .AUTO_FRAMES(3), .LOCKOUT_FRAMES(4)
  ) u_dut_pol1 (
    .pixclk_i  (clk),
    .reset_i   (rst),
    .btn_next_i(btn),
    .auto_en_i (auto_en),
    .video_o   (v1)
  );

  // Full 640x480 timing; only the first lines are reached in this run
  dvi_video_sequencer u_dut_def (
    .pixclk_i  (clk),
    .reset_i   (rst),
    .btn_next_i(btn),
    .auto_en_i (auto_en),
    .video_o   (v2)
  );

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } tv_t;

  typedef struct {
    logic rst;
    tv_t  s;
    tv_t  b;
  } exp_t;

  exp_t        tq[$];
  int unsigned pq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_ref = 0;
  exp_t        ref_e;
  exp_t        mon_e;
  logic [2:0]  cur_pat = 3'd0;

  // hs/vs hold "sync active"; polarity is applied per DUT in the monitor
  function automatic tv_t raster(input int n, input int ht, input int vt, input int ha,
                                 input int hsb, input int hse, input int va, input int vsb,
                                 input int vse);
    tv_t t;
    int  hx;
    int  vy;
    hx   = n % ht;
    vy   = (n / ht) % vt;
    t.x  = 10'(hx);
    t.y  = 10'(vy);
    t.de = (hx < ha) && (vy < va);
    t.hs = (hx >= hsb) && (hx < hse);
    t.vs = (vy >= vsb) && (vy < vse);
    t.fs = (hx == 0) && (vy == 0);
    return t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ref_e.rst = 1'b1;
      ref_e.s   = '0;
      ref_e.b   = '0;
      n_ref     = 0;
    end else begin
      ref_e.rst = 1'b0;
      ref_e.s   = raster(n_ref, 32, 12, 16, 20, 26, 6, 8, 10);
      ref_e.b   = raster(n_ref, 800, 525, 640, 656, 752, 480, 490, 492);
      n_ref++;
    end
    tq.push_back(ref_e);
  end

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got de,hs,vs,fs=%b x=%0d y=%0d pat=%0d; expected de,hs,vs,fs=%b x=%0d y=%0d pat=%0d",
               name, $time, act[26:23], act[22:13], act[12:3], act[2:0],
               exp[26:23], exp[22:13], exp[12:3], exp[2:0]);
    end
  endtask

  always @(negedge clk) begin
    if (tq.size() > 0) begin
      mon_e = tq.pop_front();
      if (mon_e.rst) begin
        cur_pat = 3'd0;
      end else if (mon_e.s.fs) begin
        if (pq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pattern_schedule t=%0t: frame start with no expected pattern queued", $time);
        end else begin
          cur_pat = 3'(pq.pop_front());
        end
      end
      check("small_pol0",
            {v0.de, v0.hsync, v0.vsync, v0.frame_start, v0.x, v0.y, v0.pattern},
            {mon_e.s.de, ~mon_e.s.hs, ~mon_e.s.vs, mon_e.s.fs, mon_e.s.x, mon_e.s.y, cur_pat});
      check("small_pol1",
            {v1.de, v1.hsync, v1.vsync, v1.frame_start, v1.x, v1.y, v1.pattern},
            {mon_e.s.de, mon_e.s.hs, mon_e.s.vs, mon_e.s.fs, mon_e.s.x, mon_e.s.y, cur_pat});
      check("default_640x480",
            {v2.de, v2.hsync, v2.vsync, v2.frame_start, v2.x, v2.y, v2.pattern},
            {mon_e.b.de, ~mon_e.b.hs, ~mon_e.b.vs, mon_e.b.fs, mon_e.b.x, mon_e.b.y, 3'd0});
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_fs();
    int c;
    c = 0;
    do begin
      tick(1);
      c++;
    end while (!v0.frame_start && c < 2 * FRAME);
    n_chk++;
    if (!v0.frame_start) begin
      n_fail++;
      $display("FAIL frame_start_timeout t=%0t: got no frame_start in %0d cycles, expected one within %0d",
               $time, c, FRAME);
    end
  endtask

  task automatic frame_to(input int unsigned exp_pat);
    pq.push_back(exp_pat);
    wait_fs();
  endtask

  task automatic press();
    btn = 1'b1;
    tick(4);
    btn = 1'b0;
    tick(4);
  endtask

  initial begin
    int unsigned cur;
    tick(3);
    rst = 1'b0;
    frame_to(0);
    frame_to(0);
    // Single press mid-frame: visible exactly at the next frame start
    tick(100);
    press();
    frame_to(1);
    repeat (4) frame_to(1);
    // Two presses in one frame advance by one only
    tick(50);
    press();
    tick(30);
    press();
    frame_to(2);
    frame_to(2);
    // Lockout still running: this press is dropped
    tick(100);
    press();
    frame_to(2);
    frame_to(2);
    frame_to(2);
    auto_en = 1'b1;
    cur = 2;
    for (int i = 0; i < 8; i++) begin
      frame_to(cur);
      frame_to(cur);
      cur = (cur + 1) % 8;
      frame_to(cur);
    end
    frame_to(2);
    frame_to(2);
    // Press pending on the auto-expiry boundary: still a single step
    tick(100);
    press();
    frame_to(3);
    frame_to(3);
    frame_to(3);
    frame_to(4);
    frame_to(4);
    frame_to(4);
    frame_to(5);
    // Mid-frame reset at x=10, y=3 with pattern 5
    tick(106);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    frame_to(0);
    frame_to(0);
    frame_to(1);
    frame_to(1);
    frame_to(1);
    // Brief auto_en drop clears the frame counter, postponing the next advance
    tick(50);
    auto_en = 1'b0;
    tick(3);
    auto_en = 1'b1;
    frame_to(1);
    frame_to(1);
    tick(20);
    n_chk++;
    if (pq.size() != 0) begin
      n_fail++;
      $display("FAIL pattern_schedule_drain: got %0d unconsumed expected patterns, expected 0",
               pq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
